// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM encoding and access-check helpers for the lsu
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  // Halfwords need an even address, words need a 4-byte aligned address.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Stores only have B/H/W; loads additionally have the unsigned B/H variants.
  function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
    if (we) return !(funct3 inside {F3_B, F3_H, F3_W});
    return !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - request/response and data-memory port bundle for the lsu
interface lsu_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_write_data;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_read_data;

  // Environment side: execute stage issuing requests plus the data memory.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_write_data, mem_read, mem_write
  );

  // The lsu itself.
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_write_data, mem_read, mem_write
  );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational load lane extract/extend and store lane merge
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pick the little-endian byte/half lane addressed by off_i and extend it.
  always_comb begin
    lane_b = word_i[7:0];
    case (off_i)
      2'd1:    lane_b = word_i[15:8];
      2'd2:    lane_b = word_i[23:16];
      2'd3:    lane_b = word_i[31:24];
      default: lane_b = word_i[7:0];
    endcase
    lane_h = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    load_o = {{24{lane_b[7]}}, lane_b};
      F3_H:    load_o = {{16{lane_h[15]}}, lane_h};
      F3_BU:   load_o = {24'd0, lane_b};
      F3_HU:   load_o = {16'd0, lane_h};
      default: load_o = word_i;
    endcase
  end

  // Overlay the store bytes onto the memory word, leaving other lanes intact.
  always_comb begin
    merge_o = word_i;
    case (funct3_i)
      F3_B: begin
        case (off_i)
          2'd0:    merge_o[7:0]   = wdata_i[7:0];
          2'd1:    merge_o[15:8]  = wdata_i[7:0];
          2'd2:    merge_o[23:16] = wdata_i[7:0];
          default: merge_o[31:24] = wdata_i[7:0];
        endcase
      end
      F3_H: begin
        if (off_i[1]) merge_o[31:16] = wdata_i[15:0];
        else          merge_o[15:0]  = wdata_i[15:0];
      end
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load/store unit in front of a word-only data memory
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic   clk,
  input logic   rst,
  lsu_if.slave  bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       load_data;
  logic [31:0]       merge_data;
  logic              bad_req;

  lsu_align u_align (
    .funct3_i (funct3_q),
    .off_i    (addr_q[1:0]),
    .word_i   (bus.mem_read_data),
    .wdata_i  (wdata_q),
    .load_o   (load_data),
    .merge_o  (merge_data)
  );

  assign bad_req = is_illegal(bus.req_we, bus.req_funct3)
                 | is_misaligned(bus.req_funct3, bus.req_addr[1:0]);

  // Next-state and datapath updates; memory strobes follow directly from the state.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    wdata_d  = wdata_q;
    buf_d    = buf_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          addr_d   = bus.req_addr;
          funct3_d = bus.req_funct3;
          wdata_d  = bus.req_wdata;
          err_d    = bad_req;
          if (bad_req) begin
            rdata_d = '0;
            state_d = ST_RESP;
          end else if (!bus.req_we) begin
            state_d = ST_LOAD;
          end else if (bus.req_funct3 == F3_W) begin
            buf_d   = bus.req_wdata;
            rdata_d = '0;
            state_d = ST_WRITE;
          end else begin
            rdata_d = '0;
            state_d = ST_RMW_RD;
          end
        end
      end
      ST_LOAD: begin
        rdata_d = load_data;
        state_d = ST_RESP;
      end
      ST_RMW_RD: begin
        buf_d   = merge_data;
        state_d = ST_WRITE;
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
      buf_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      wdata_q  <= wdata_d;
      buf_q    <= buf_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign bus.req_ready      = (state_q == ST_IDLE);
  assign bus.resp_valid     = (state_q == ST_RESP);
  assign bus.resp_err       = (state_q == ST_RESP) & err_q;
  assign bus.resp_rdata     = rdata_q;
  assign bus.mem_addr       = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.mem_write_data = buf_q;
  assign bus.mem_read       = (state_q == ST_LOAD) | (state_q == ST_RMW_RD);
  assign bus.mem_write      = (state_q == ST_WRITE);

endmodule
